// File: rtl/led_row_scanner.sv
// LED matrix row scanner: shifts each 24-column row out serially, latches it, then holds it lit.
// Build option LED_ROW_SCANNER_BLANK_EN: drive the row/enable only during HOLD instead of continuously.
module led_row_scanner #(
  parameter int CLK_DIV     = 2,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [119:0] frame_in,
  input  logic         frame_load,
  output logic [4:0]   row_sel,
  output logic         ser_data,
  output logic         ser_clk,
  output logic         ser_latch,
  output logic         oe_n,
  output logic         frame_done
);

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH,
    S_HOLD
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [15:0]    r_cnt;
  logic [4:0]     r_bit;
  logic [2:0]     r_row;
  logic [23:0]    r_shift;
  logic [119:0]   r_pending;
  logic [119:0]   r_active;

  logic           w_boundary;
  logic [119:0]   w_frame_src;
  logic [119:0]   w_row_src;
  logic [23:0]    w_rows [5];
  logic [23:0]    w_row_data;
  logic           w_div_done;
  logic           w_hold_done;
  logic [4:0]     w_row_onehot;

  // A load landing on the row-0 LOAD cycle must be scanned in that very frame.
  assign w_boundary  = (r_state == S_LOAD) && (r_row == 3'd0);
  assign w_frame_src = frame_load ? frame_in : r_pending;
  assign w_row_src   = w_boundary ? w_frame_src : r_active;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_rows
      assign w_rows[gi] = w_row_src[119 - 24*gi -: 24];
    end
  endgenerate

  assign w_row_data   = w_rows[r_row];
  assign w_div_done   = (r_cnt == DIV_LAST);
  assign w_hold_done  = (r_cnt == HOLD_LAST);
  assign w_row_onehot = 5'd1 << r_row;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD:     w_state_next = S_SHIFT_LO;
      S_SHIFT_LO: if (w_div_done) w_state_next = S_SHIFT_HI;
      S_SHIFT_HI: if (w_div_done) w_state_next = (r_bit == 5'd23) ? S_LATCH : S_SHIFT_LO;
      S_LATCH:    w_state_next = S_HOLD;
      S_HOLD:     if (w_hold_done) w_state_next = S_LOAD;
      default:    w_state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_LOAD;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_row     <= '0;
      r_shift   <= '0;
      r_pending <= '0;
      r_active  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= (w_state_next != r_state) ? 16'd0 : r_cnt + 16'd1;
      if (frame_load) r_pending <= frame_in;
      case (r_state)
        S_LOAD: begin
          r_shift <= w_row_data;
          r_bit   <= '0;
          if (w_boundary) r_active <= w_frame_src;
        end
        S_SHIFT_HI: begin
          // The last bit stays on ser_data through LATCH/HOLD; it only moves on SHIFT_LO entry.
          if (w_div_done && r_bit != 5'd23) begin
            r_shift <= {r_shift[22:0], 1'b0};
            r_bit   <= r_bit + 5'd1;
          end
        end
        S_HOLD: begin
          if (w_hold_done) r_row <= (r_row == 3'd4) ? 3'd0 : r_row + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign ser_data   = r_shift[23];
  assign ser_clk    = (r_state == S_SHIFT_HI);
  assign ser_latch  = (r_state == S_LATCH);
  assign frame_done = (r_state == S_HOLD) && (r_row == 3'd4) && w_hold_done;

`ifdef LED_ROW_SCANNER_BLANK_EN
  assign row_sel = (r_state == S_HOLD) ? w_row_onehot : 5'd0;
  assign oe_n    = (r_state != S_HOLD);
`else
  logic [4:0] r_row_sel;
  logic       r_oe_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_sel <= '0;
      r_oe_n    <= 1'b1;
    end else if (r_state == S_LATCH) begin
      r_row_sel <= w_row_onehot;
      r_oe_n    <= 1'b0;
    end
  end

  assign row_sel = r_row_sel;
  assign oe_n    = r_oe_n;
`endif

endmodule

// File: doc/led_row_scanner.md
LED_ROW_SCANNER -- requirements
Module: led_row_scanner

Interface
REQ-001 Parameter CLK_DIV, default 2, is the number of clk cycles per ser_clk half-period, legal range 1..255.
REQ-002 Parameter HOLD_CYCLES, default 1000, is the number of clk cycles a latched row stays displayed, legal range 1..65535.
REQ-003 clk  input  1  is the system clock; all logic is on its rising edge.
REQ-004 reset  input  1  is the reset: synchronous, active-high.
REQ-005 frame_in  input  120  is the frame image: row r occupies bits [119-24r : 96-24r] for r=0..4, and bit 23 of each row is the leftmost column.
REQ-006 frame_load  input  1  is a single-cycle strobe that captures frame_in into the pending buffer.
REQ-007 row_sel  output  5  is the one-hot row driver, with bit r selecting row r.
REQ-008 ser_data  output  1  is the column shift-register data, sent MSB first.
REQ-009 ser_clk  output  1  is the column shift-register clock; the external register samples on its rising edge.
REQ-010 ser_latch  output  1  is the column register storage strobe, one clk cycle wide.
REQ-011 oe_n  output  1  is the active-low column output enable.
REQ-012 frame_done  output  1  is a one-cycle pulse at the end of each complete 5-row scan, intended to drive the pattern generator's NextPattern.

Function
REQ-013 Buffering SHALL use a pending 120-bit register written on frame_load and an active 120-bit register copied from pending only when the scan begins row 0 (a frame boundary).
REQ-014 If frame_load and a frame boundary coincide in the same cycle, the newly loaded frame_in SHALL become active.
REQ-015 The FSM SHALL have the states LOAD, SHIFT_LO, SHIFT_HI, LATCH and HOLD; its entry state after reset is LOAD with the row counter at 0.
REQ-016 LOAD SHALL last 1 cycle, load the 24-bit shift register with the current row, drive ser_data with bit 23, and then go to SHIFT_LO.
REQ-017 SHIFT_LO SHALL hold ser_clk=0 for CLK_DIV cycles and then go to SHIFT_HI.
REQ-018 SHIFT_HI SHALL hold ser_clk=1 for CLK_DIV cycles.
REQ-019 On leaving SHIFT_HI, the FSM SHALL shift the register left, present the next bit on ser_data, and return to SHIFT_LO until 24 bits have been sent.
REQ-020 After the 24th bit, SHIFT_HI SHALL go to LATCH.
REQ-021 LATCH SHALL last 1 cycle with ser_latch=1.
REQ-022 row_sel SHALL switch to the one-hot code of the current row on the cycle after LATCH.
REQ-023 HOLD SHALL last HOLD_CYCLES cycles.
REQ-024 The row counter SHALL advance at the end of HOLD and wrap from 4 to 0, then the FSM SHALL return to LOAD.
REQ-025 The row period SHALL be exactly 2 + 48*CLK_DIV + HOLD_CYCLES cycles, and the frame period SHALL be exactly 5 row periods.
REQ-026 frame_done SHALL be high for exactly the last HOLD cycle of row 4.
REQ-027 ser_clk SHALL be 0 in LOAD, LATCH and HOLD.
REQ-028 ser_data SHALL change only on entry to SHIFT_LO or LOAD.
REQ-029 Before the first frame_load, the active frame SHALL be all zero and scanning SHALL run continuously.
REQ-030 frame_load during a scan SHALL NOT alter the frame being scanned.

Reset
REQ-031 While reset=1, the outputs SHALL be row_sel=0, ser_data=0, ser_clk=0, ser_latch=0, oe_n=1 and frame_done=0.
REQ-032 While reset=1, the pending and active buffers SHALL be cleared to zero and the row counter SHALL be set to 0.
REQ-033 Reset asserted mid-row or mid-frame SHALL abort the scan within the same clk edge, with no partial latch.
REQ-034 After reset is released, the first cycle SHALL be LOAD for row 0.

Configuration
REQ-035 The macro LED_ROW_SCANNER_BLANK_EN SHALL select between blanked and continuous row driving.
REQ-036 With LED_ROW_SCANNER_BLANK_EN defined, oe_n SHALL be 0 and row_sel non-zero only during HOLD; otherwise row_sel=0 and oe_n=1.
REQ-037 Without LED_ROW_SCANNER_BLANK_EN, oe_n SHALL go to 0 at the first LATCH after reset and stay 0.
REQ-038 Without LED_ROW_SCANNER_BLANK_EN, row_sel SHALL hold the previous row until the cycle after the next LATCH; before the first latch it SHALL be 0.

Verification
REQ-039 Reset timing (CLK_DIV=1, HOLD_CYCLES=4, no load): release reset -> the row period is 54 cycles, frame_done pulses every 270 cycles, row_sel cycles 01,02,04,08,10 and ser_data stays 0.
REQ-040 Serial data: frame_load with row0=24'h0000FF and the other rows zero -> row 0 emits 16 zeros then 8 ones on 24 ser_clk rising edges, then ser_latch pulses; rows 1-4 emit all zeros.
REQ-041 Frame-boundary buffering: assert frame_load with 24'hFFFFFF in every row during row 2 of a frame -> the rows of that frame are unchanged, and the next frame's row 0 emits all ones.
REQ-042 Coincident load: assert frame_load in the cycle the scan enters row 0 -> the new data is shifted in that same row 0.
REQ-043 Mid-shift reset: assert reset after the 10th ser_clk of row 3 -> outputs take their reset values on the next edge, no ser_latch pulse occurs, and the scan restarts with LOAD for row 0.
REQ-044 Blanking: with LED_ROW_SCANNER_BLANK_EN defined -> oe_n is low for exactly HOLD_CYCLES cycles per row; with it undefined -> oe_n stays low continuously after the first latch.
